// File: rtl/spine_router_pkg.sv
// Shared spine-router constants: port counts, port-id ranges and the output-port arbiter states.
package spine_router_pkg;

  localparam int unsigned SPINE_NUM_PORTS = 11;
  localparam int unsigned NUM_LEAF_PORTS  = 4;
  localparam int unsigned NUM_GROUP_PORTS = 7;
  localparam int unsigned LEAF_PORT_BASE  = 0;
  localparam int unsigned GROUP_PORT_BASE = NUM_LEAF_PORTS;
  localparam int unsigned PORT_ID_W       = $clog2(SPINE_NUM_PORTS);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular first-one picker: first unmasked request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned N = 11,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] cand;
  logic [W:0]   pos_full;
  logic [W-1:0] pos;

  assign cand = req & ~mask;

  // ptr is always below N, so a single conditional subtract wraps the position.
  always_comb begin
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    pos_full = '0;
    pos      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos_full = {1'b0, ptr} + (W+1)'(i);
      if (pos_full >= (W+1)'(N)) begin
        pos_full = pos_full - (W+1)'(N);
      end
      pos = pos_full[W-1:0];
      if (!any && cand[pos]) begin
        onehot[pos] = 1'b1;
        idx         = pos;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spine_port_arbiter.sv
// Wormhole round-robin arbiter for one spine output port: packet-level grants with backpressure,
// zero-bubble re-arbitration on the tail flit and a flit-count watchdog.
module spine_port_arbiter
  import spine_router_pkg::*;
#(
  parameter int unsigned NUM_REQ       = SPINE_NUM_PORTS,
  parameter int unsigned MAX_PKT_FLITS = 16,
  localparam int unsigned ID_W         = $clog2(NUM_REQ),
  localparam int unsigned CNT_W        = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               out_full,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               xfer,
  output logic               pkt_done,
  output logic               timeout_err
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
  logic               pkt_done_q, pkt_done_d;
  logic               timeout_q, timeout_d;

  logic               busy;
  logic               cur_last;
  logic               tail;
  logic               wd_hit;
  logic               release_pkt;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  assign busy        = (state_q == ARB_BUSY);
  assign xfer        = busy & (|(req & gnt_q)) & ~out_full;
  assign cur_last    = |(req_last & gnt_q);
  assign tail        = xfer & cur_last;
  assign wd_hit      = xfer & ~cur_last & (flit_cnt_q == CNT_W'(MAX_PKT_FLITS - 1));
  assign release_pkt = tail | wd_hit;
  assign next_ptr    = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

  // One picker serves both paths: IDLE uses rr_ptr, a releasing BUSY cycle masks the finisher.
  assign pick_ptr  = busy ? next_ptr : rr_ptr_q;
  assign pick_mask = busy ? gnt_q : '0;

  rr_priority_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (pick_mask),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    flit_cnt_d = flit_cnt_q;
    pkt_done_d = tail;
    timeout_d  = wd_hit;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d  = ARB_BUSY;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (xfer) begin
          flit_cnt_d = flit_cnt_q + CNT_W'(1);
        end
        if (release_pkt) begin
          flit_cnt_d = '0;
          rr_ptr_d   = next_ptr;
          if (pick_any) begin
            gnt_d    = pick_onehot;
            gnt_id_d = pick_idx;
          end else begin
            state_d  = ARB_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      gnt_q      <= '0;
      flit_cnt_q <= '0;
      pkt_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      gnt_q      <= gnt_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_done_q <= pkt_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = busy;
  assign gnt_id      = gnt_id_q;
  assign pkt_done    = pkt_done_q;
  assign timeout_err = timeout_q;

endmodule
